// File: rtl/core_ctrl_if.sv
// core_ctrl_if: host-side data/handshake and core-side instruction bus of the layer sequencer.
interface core_ctrl_if #(parameter int bw = 4, parameter int row = 8);
  logic start;
  logic [10:0] num_x;
  logic [3:0] num_k;
  logic in_valid;
  logic [bw*row-1:0] in_data;
  logic in_ready;
  logic ofifo_valid;
  logic [33:0] inst;
  logic [bw*row-1:0] D_xmem;
  logic busy;
  logic done;
  modport master(input start, num_x, num_k, in_valid, in_data, ofifo_valid, output in_ready, inst, D_xmem, busy, done);
  modport slave(output start, num_x, num_k, in_valid, in_data, ofifo_valid, input in_ready, inst, D_xmem, busy, done);
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl: layer instruction sequencer; loads xmem, then per kernel tile loads weights,
// streams activations, executes and drains OFIFO into pmem.
module core_ctrl #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int bw = 4,
  parameter int W_BASE = 1024
) (
  input logic clk,
  input logic reset,
  core_ctrl_if.master bus
);
  typedef enum logic [3:0] {IDLE, XWR, WWR, KL0, KLD, XL0, EXE, DRAIN, DONE} state_t;
  state_t state;
  logic [10:0] cnt, nx, pa, wlen, wbase;
  logic [3:0] k, nk;
  logic [bw*row-1:0] din;
  logic acc;
  // inst layout: [32]CEN_P [31]WEN_P [30:20]A_P [19]CEN_X [18]WEN_X [17:7]A_X [6]OFIFO_RD [3]L0_RD [2]L0_WR [1]EXEC [0]LOAD
  localparam logic [33:0] IDLE_INST = {1'b0, 2'b11, 11'd0, 2'b11, 11'd0, 7'd0};
  function automatic logic [33:0] mk(logic cx, logic wx, logic [10:0] ax, logic cp, logic wp,
                                     logic [10:0] ap, logic of, logic lr, logic lw, logic ex, logic ld);
    return {1'b0, cp, wp, ap, cx, wx, ax, of, 2'b00, lr, lw, ex, ld};
  endfunction
  assign wlen = 11'(nk) * 11'(row);
  assign wbase = 11'(W_BASE) + 11'(k) * 11'(row);
  assign din = bus.in_data;
  assign acc = bus.in_valid & bus.in_ready;
  // inst is emitted one edge after the state/counter position that produces it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      nx <= '0;
      nk <= '0;
      k <= '0;
      pa <= '0;
      bus.inst <= IDLE_INST;
      bus.D_xmem <= '0;
      bus.in_ready <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.inst <= IDLE_INST;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start && !bus.done) begin
          nx <= bus.num_x;
          nk <= bus.num_k;
          cnt <= '0;
          k <= '0;
          pa <= '0;
          if (bus.num_x == 11'd0 || bus.num_k == 4'd0) bus.done <= 1'b1;
          else begin
            state <= XWR;
            bus.in_ready <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        XWR, WWR: if (acc) begin
          bus.inst <= mk(1'b0, 1'b0, state == XWR ? cnt : 11'(W_BASE) + cnt, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          bus.D_xmem <= din;
          cnt <= cnt + 11'd1;
          if (cnt == (state == XWR ? nx : wlen) - 11'd1) begin
            cnt <= '0;
            state <= state == XWR ? WWR : KL0;
            bus.in_ready <= (state == XWR);
          end
        end
        KL0: begin
          bus.inst <= mk(cnt == 11'(row), 1'b1, cnt < 11'(row) ? wbase + cnt : 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, cnt != 11'd0, 1'b0, 1'b0);
          cnt <= cnt == 11'(row) ? 11'd0 : cnt + 11'd1;
          if (cnt == 11'(row)) state <= KLD;
        end
        KLD: begin
          bus.inst <= cnt < 11'(row) ? mk(1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1) : IDLE_INST;
          cnt <= cnt == 11'(row + col - 1) ? 11'd0 : cnt + 11'd1;
          if (cnt == 11'(row + col - 1)) state <= XL0;
        end
        XL0: begin
          bus.inst <= mk(cnt == nx, 1'b1, cnt < nx ? cnt : 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b0, cnt != 11'd0, 1'b0, 1'b0);
          cnt <= cnt == nx ? 11'd0 : cnt + 11'd1;
          if (cnt == nx) state <= EXE;
        end
        EXE: begin
          bus.inst <= mk(1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
          cnt <= cnt == nx - 11'd1 ? 11'd0 : cnt + 11'd1;
          if (cnt == nx - 11'd1) state <= DRAIN;
        end
        DRAIN: if (bus.ofifo_valid) begin
          bus.inst <= mk(1'b1, 1'b1, 11'd0, 1'b0, 1'b0, pa, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
          pa <= pa + 11'd1;
          cnt <= cnt + 11'd1;
          if (cnt == nx - 11'd1) begin
            cnt <= '0;
            k <= k + 4'd1;
            state <= k == nk - 4'd1 ? DONE : KL0;
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: randomized host/OFIFO stimulus against an event-list model of one layer.
module tb_core_ctrl;
  localparam int ROW = 8, COL = 8, BW = 4, WB = 1024;
  localparam logic [33:0] IDLE_I = 34'h1_800C_0000;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0, passed = 0, fails = 0;
  logic [31:0] hq[$], wd[$];
  logic [10:0] wa[$], rq[$], pq[$];
  logic acc_prev = 0, ofv_prev = 0, xr_prev = 0, stall = 0;
  int vmode = 0, tog = 0, lrun = 0, erun = 0, gap = -1, ld_tot = 0, ex_tot = 0, pcnt = 0, cur_nx = 0, dseen = 0;
  logic cx, wx, cp, wp, of, lr, lw, ex, ld;
  logic [10:0] ax, ap;
  core_ctrl_if #(.bw(BW), .row(ROW)) bus ();
  core_ctrl #(.row(ROW), .col(COL), .bw(BW), .W_BASE(WB)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign cp = bus.inst[32];
  assign wp = bus.inst[31];
  assign ap = bus.inst[30:20];
  assign cx = bus.inst[19];
  assign wx = bus.inst[18];
  assign ax = bus.inst[17:7];
  assign of = bus.inst[6];
  assign lr = bus.inst[3];
  assign lw = bus.inst[2];
  assign ex = bus.inst[1];
  assign ld = bus.inst[0];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic xw, xr, pw;
    @(negedge clk);
    xw = !cx && !wx;
    xr = !cx && wx;
    pw = !cp && !wp;
    chk("xmem_wr_on_accept", xw, acc_prev);
    if (xw) begin
      chk("xmem_wr_pending", wa.size() > 0, 1);
      if (wa.size() > 0) begin
        chk("xmem_wr_addr", ax, wa.pop_front());
        chk("xmem_wr_data", bus.D_xmem, wd.pop_front());
      end
    end
    if (xr) begin
      chk("xmem_rd_pending", rq.size() > 0, 1);
      if (rq.size() > 0) chk("xmem_rd_addr", ax, rq.pop_front());
    end
    chk("l0_wr_lags_read", lw, xr_prev);
    chk("pmem_wr_with_ofifo_rd", pw, of);
    chk("ofifo_rd_needs_valid", of & ~ofv_prev, 0);
    if (pw) begin
      chk("pmem_pending", pq.size() > 0, 1);
      if (pq.size() > 0) chk("pmem_addr", ap, pq.pop_front());
      pcnt++;
    end
    chk("l0_rd_with_load_or_exec", lr, ld | ex);
    chk("spare_bits_zero", {bus.inst[33], bus.inst[5:4]}, 0);
    chk("in_ready_only_when_words_due", bus.in_ready & (wa.size() == 0), 0);
    if (ld) begin lrun++; ld_tot++; end
    else if (lrun > 0) begin chk("load_run_len", lrun, ROW); lrun = 0; gap = 0; end
    if (gap >= 0 && !ld) begin
      if (bus.inst === IDLE_I) gap++;
      else begin chk("post_load_idle_gap", gap, COL); gap = -1; end
    end
    if (ex) begin erun++; ex_tot++; end
    else if (erun > 0) begin chk("exec_run_len", erun, cur_nx); erun = 0; end
    if (bus.done) dseen++;
    xr_prev = xr;
    bus.in_valid = hq.size() > 0 && (vmode == 1 || (vmode == 2 ? (tog % 2 == 0) : ($urandom_range(0, 1) == 1)));
    tog++;
    bus.in_data = hq.size() > 0 ? hq[0] : $urandom;
    acc_prev = bus.in_valid && bus.in_ready;
    if (acc_prev) void'(hq.pop_front());
    bus.ofifo_valid = !stall && $urandom_range(0, 2) != 0;
    ofv_prev = bus.ofifo_valid;
  endtask

  task automatic mreset();
    hq.delete(); wd.delete(); wa.delete(); rq.delete(); pq.delete();
    acc_prev = 0; ofv_prev = 0; xr_prev = 0; lrun = 0; erun = 0; gap = -1;
  endtask

  task automatic go(int nx, int nk);
    logic [31:0] d;
    if (nx > 0 && nk > 0) begin
      for (int i = 0; i < nx + nk * ROW; i++) begin
        d = $urandom;
        hq.push_back(d);
        wd.push_back(d);
        wa.push_back(11'(i < nx ? i : WB + i - nx));
      end
      for (int t = 0; t < nk; t++) begin
        for (int i = 0; i < ROW; i++) rq.push_back(11'(WB + t * ROW + i));
        for (int j = 0; j < nx; j++) begin
          rq.push_back(11'(j));
          pq.push_back(11'((t * nx + j) % 2048));
        end
      end
    end
    cur_nx = nx; pcnt = 0; dseen = 0; ld_tot = 0; ex_tot = 0;
    bus.num_x = 11'(nx);
    bus.num_k = 4'(nk);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic finish_layer(int nx, int nk);
    int n = 0;
    while (!bus.done && n < 20000) begin
      chk("busy_while_running", bus.busy, 1);
      cycle();
      n++;
    end
    chk("layer_finished_in_time", bus.done, 1);
    chk("busy_low_at_done", bus.busy, 0);
    chk("xmem_writes_all_seen", wa.size(), 0);
    chk("xmem_reads_all_seen", rq.size(), 0);
    chk("pmem_writes_all_seen", pq.size(), 0);
    chk("load_cycles", ld_tot, nk * ROW);
    chk("exec_cycles", ex_tot, nk * nx);
    chk("pmem_write_count", pcnt, nk * nx);
    cycle();
    chk("done_single_pulse", dseen, 1);
    chk("done_low_after", bus.done, 0);
    chk("in_ready_low_after", bus.in_ready, 0);
  endtask

  initial begin
    int n;
    bus.start = 0; bus.num_x = 0; bus.num_k = 0; bus.in_valid = 0; bus.in_data = 0; bus.ofifo_valid = 0;
    repeat (3) @(negedge clk);
    chk("reset_inst", bus.inst, IDLE_I);
    chk("reset_dxmem", bus.D_xmem, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    reset = 1'b1;
    cycle();
    chk("idle_inst_after_release", bus.inst, IDLE_I);
    // directed small layer with valid held high and a start while busy
    vmode = 1;
    go(4, 1);
    repeat (3) cycle();
    bus.num_x = 11'd7; bus.num_k = 4'd3; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0; bus.num_x = 11'd4; bus.num_k = 4'd1;
    finish_layer(4, 1);
    vmode = 2;
    go(6, 2);
    finish_layer(6, 2);
    // OFIFO stall in the middle of a drain
    vmode = 0;
    go(5, 2);
    n = 0;
    while (pcnt < 2 && n < 3000) begin cycle(); n++; end
    chk("drain_reached", pcnt >= 2, 1);
    stall = 1;
    repeat (2) cycle();
    repeat (12) begin
      cycle();
      chk("stall_inst_idle", bus.inst, IDLE_I);
      chk("stall_busy", bus.busy, 1);
    end
    stall = 0;
    finish_layer(5, 2);
    // zero-size layers, and a start coinciding with done
    go(5, 0);
    chk("zero_k_done", bus.done, 1);
    chk("zero_k_busy", bus.busy, 0);
    bus.num_x = 11'd4; bus.num_k = 4'd1; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk("start_during_done_ignored", bus.busy, 0);
    chk("zero_k_done_pulse", bus.done, 0);
    go(0, 3);
    chk("zero_x_done", bus.done, 1);
    cycle();
    chk("zero_x_done_pulse", bus.done, 0);
    chk("zero_x_busy", bus.busy, 0);
    go(16, 9);
    finish_layer(16, 9);
    go(3, 2);
    finish_layer(3, 2);
    // abort during execute
    go(16, 9);
    n = 0;
    while (ex_tot < 3 && n < 2000) begin cycle(); n++; end
    chk("reached_exec", ex_tot >= 3, 1);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("abort_inst_idle", bus.inst, IDLE_I);
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_done", bus.done, 0);
    bus.in_valid = 0;
    bus.ofifo_valid = 1;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("no_activity_after_abort", bus.inst, IDLE_I);
    end
    chk("abort_stays_idle", bus.busy, 0);
    bus.ofifo_valid = 0;
    mreset();
    go(3, 1);
    finish_layer(3, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
